// File: rtl/fwd_stall_unit_pkg.sv
// fwd_stall_unit_pkg: opcodes, multdiv ALU ops, forwarding selects and multdiv FSM states
package fwd_stall_unit_pkg;
  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [1:0] FWD_XM  = 2'b00;
  localparam logic [1:0] FWD_MW  = 2'b01;
  localparam logic [1:0] FWD_RF  = 2'b10;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
  function automatic logic is_writer(input logic [4:0] op);
    return op inside {OP_R, OP_ADDI, OP_LW, OP_SETX, OP_JAL};
  endfunction
  function automatic logic has_src_b(input logic [4:0] op);
    return op inside {OP_R, OP_SW, OP_BNE, OP_BLT, OP_JR, OP_BEX};
  endfunction
endpackage

// File: rtl/fwd_stall_unit_md_stall_fsm.sv
// md_stall_fsm: multiply/divide stall sequencer with latency down-counter
module md_stall_fsm
  import fwd_stall_unit_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic md_op,
  output logic md_start,
  output logic md_busy,
  output logic md_stall
);
  md_state_t state;
  logic [7:0] cnt;
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: if (md_op) begin
          state <= MD_BUSY;
          cnt   <= 8'(MD_LATENCY - 1);
        end
        MD_BUSY: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= MD_DONE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
  assign md_start = !reset && !flush && state == MD_IDLE && md_op;
  assign md_stall = !reset && !flush && (state == MD_BUSY || (state == MD_IDLE && md_op));
  assign md_busy  = !reset && state != MD_IDLE;
endmodule

// File: rtl/fwd_stall_unit.sv
// fwd_stall_unit: bypass selects and load-use/multdiv stalls; perf counters exist only with FWD_PERF_CNT_EN
module fwd_stall_unit
  import fwd_stall_unit_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 32,
  parameter int STAT_REG   = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic [31:0] xm_ir,
  input  logic [31:0] mw_ir,
  input  logic        xm_ovf,
  input  logic        mw_ovf,
  input  logic        flush,
  output logic [1:0]  muxA_sel,
  output logic [1:0]  muxB_sel,
  output logic        wm_sel,
  output logic        stall,
  output logic        bubble,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] md_stall_cnt
);
  typedef logic [REG_AW-1:0] reg_t;
  function automatic reg_t dest_of(input logic [4:0] op, input logic [4:0] rd, input logic ovf);
    return op == OP_JAL ? reg_t'(31) : (op == OP_SETX || ovf) ? reg_t'(STAT_REG) : reg_t'(rd);
  endfunction
  function automatic reg_t src_b_of(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rt);
    return op == OP_R ? reg_t'(rt) : op == OP_BEX ? reg_t'(STAT_REG) : reg_t'(rd);
  endfunction
  logic [4:0] fd_op, dx_op, xm_op, mw_op;
  reg_t xm_dest, mw_dest, dx_a, dx_b, fd_a, fd_b, dx_ld_dest;
  logic xm_hit, mw_hit, dx_has_b, fd_has_b, lu_hazard, lu_stall, md_op, md_stall;
  logic unused_bits;
  assign fd_op = fd_ir[31:27];
  assign dx_op = dx_ir[31:27];
  assign xm_op = xm_ir[31:27];
  assign mw_op = mw_ir[31:27];
  assign xm_dest = dest_of(xm_op, xm_ir[26:22], xm_ovf);
  assign mw_dest = dest_of(mw_op, mw_ir[26:22], mw_ovf);
  // a zero destination never bypasses, and an XM load has no data yet
  assign xm_hit = is_writer(xm_op) && xm_op != OP_LW && xm_dest != '0;
  assign mw_hit = is_writer(mw_op) && mw_dest != '0;
  assign dx_a = reg_t'(dx_ir[21:17]);
  assign dx_b = src_b_of(dx_op, dx_ir[26:22], dx_ir[16:12]);
  assign dx_has_b = has_src_b(dx_op);
  assign muxA_sel = (xm_hit && xm_dest == dx_a) ? FWD_XM : (mw_hit && mw_dest == dx_a) ? FWD_MW : FWD_RF;
  assign muxB_sel = !dx_has_b ? FWD_RF : (xm_hit && xm_dest == dx_b) ? FWD_XM :
                    (mw_hit && mw_dest == dx_b) ? FWD_MW : FWD_RF;
  assign wm_sel = xm_op == OP_SW && mw_op == OP_LW && mw_dest == reg_t'(xm_ir[26:22]) && mw_dest != '0;
  assign fd_a = reg_t'(fd_ir[21:17]);
  assign fd_b = src_b_of(fd_op, fd_ir[26:22], fd_ir[16:12]);
  assign fd_has_b = has_src_b(fd_op);
  assign dx_ld_dest = reg_t'(dx_ir[26:22]);
  // a store's data field is satisfied by the MW->store bypass, so only its base forces a stall
  assign lu_hazard = dx_op == OP_LW && dx_ld_dest != '0 &&
                     (dx_ld_dest == fd_a || (fd_has_b && fd_op != OP_SW && dx_ld_dest == fd_b));
  assign md_op = dx_op == OP_R && (dx_ir[6:2] == ALU_MUL || dx_ir[6:2] == ALU_DIV);
  md_stall_fsm #(.MD_LATENCY(MD_LATENCY)) u_md (
    .clock(clock), .reset(reset), .flush(flush), .md_op(md_op),
    .md_start(md_start), .md_busy(md_busy), .md_stall(md_stall)
  );
  assign lu_stall = !reset && !flush && !md_stall && lu_hazard;
  assign stall  = md_stall || lu_stall;
  assign bubble = stall;
  assign unused_bits = ^{fd_ir[11:0], dx_ir[11:7], dx_ir[1:0], xm_ir[21:0], mw_ir[21:0]};
`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      lu_stall_cnt <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (lu_stall && !(&lu_stall_cnt)) lu_stall_cnt <= lu_stall_cnt + 32'd1;
      if (md_stall && !(&md_stall_cnt)) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`else
  assign lu_stall_cnt = '0;
  assign md_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_stall_unit.sv
// tb_fwd_stall_unit: directed forwarding, load-use and multdiv stall checks
module tb_fwd_stall_unit;
  import fwd_stall_unit_pkg::*;
`ifdef FWD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] fd_ir = '0, dx_ir = '0, xm_ir = '0, mw_ir = '0;
  logic xm_ovf = 1'b0, mw_ovf = 1'b0, flush = 1'b0;
  logic [1:0] muxA_sel, muxB_sel;
  logic wm_sel, stall, bubble, md_start, md_busy;
  logic [31:0] lu_stall_cnt, md_stall_cnt;
  int checks = 0;
  int errors = 0;
  fwd_stall_unit #(.REG_AW(5), .MD_LATENCY(4), .STAT_REG(30)) dut (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir), .xm_ir(xm_ir), .mw_ir(mw_ir),
    .xm_ovf(xm_ovf), .mw_ovf(mw_ovf), .flush(flush), .muxA_sel(muxA_sel), .muxB_sel(muxB_sel),
    .wm_sel(wm_sel), .stall(stall), .bubble(bubble), .md_start(md_start), .md_busy(md_busy),
    .lu_stall_cnt(lu_stall_cnt), .md_stall_cnt(md_stall_cnt)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  function automatic logic [31:0] rtype(input logic [4:0] alu, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {OP_R, rd, rs, rt, 5'd0, alu, 2'd0};
  endfunction
  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs);
    return {op, rd, rs, 17'd0};
  endfunction
  initial begin
    tick;
    dx_ir = rtype(ALU_MUL, 1, 2, 3);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bubble", 32'(bubble), 0);
    chk("rst_md_start", 32'(md_start), 0);
    tick;
    chk("rst_md_busy", 32'(md_busy), 0);
    chk("rst_lu_cnt", lu_stall_cnt, 0);
    chk("rst_md_cnt", md_stall_cnt, 0);
    dx_ir = '0;
    reset = 1'b0;
    tick;
    xm_ir = rtype(5'd0, 3, 1, 2);
    dx_ir = rtype(5'd0, 5, 3, 3);
    #1;
    chk("xm_fwd_a", 32'(muxA_sel), 32'(FWD_XM));
    chk("xm_fwd_b", 32'(muxB_sel), 32'(FWD_XM));
    xm_ir = itype(OP_LW, 3, 0);
    mw_ir = itype(OP_ADDI, 3, 0);
    dx_ir = rtype(5'd1, 1, 3, 2);
    #1;
    chk("lw_skip_a", 32'(muxA_sel), 32'(FWD_MW));
    chk("lw_skip_b", 32'(muxB_sel), 32'(FWD_RF));
    mw_ir = '0;
    xm_ovf = 1'b1;
    xm_ir = rtype(5'd0, 7, 1, 2);
    dx_ir = {OP_BEX, 27'd0};
    #1;
    chk("ovf_bex_b", 32'(muxB_sel), 32'(FWD_XM));
    chk("ovf_bex_a", 32'(muxA_sel), 32'(FWD_RF));
    xm_ovf = 1'b0;
    xm_ir = rtype(5'd0, 0, 1, 2);
    dx_ir = rtype(5'd0, 1, 0, 0);
    #1;
    chk("r0_a", 32'(muxA_sel), 32'(FWD_RF));
    chk("r0_b", 32'(muxB_sel), 32'(FWD_RF));
    xm_ir = itype(OP_BNE, 5, 0);
    mw_ir = itype(OP_JAL, 0, 0);
    dx_ir = rtype(5'd0, 1, 5, 31);
    #1;
    chk("bne_nowr_a", 32'(muxA_sel), 32'(FWD_RF));
    chk("jal_r31_b", 32'(muxB_sel), 32'(FWD_MW));
    xm_ir = itype(OP_ADDI, 4, 0);
    mw_ir = '0;
    dx_ir = itype(OP_SW, 4, 2);
    #1;
    chk("sw_data_b", 32'(muxB_sel), 32'(FWD_XM));
    xm_ir = itype(OP_SW, 6, 1);
    mw_ir = itype(OP_LW, 6, 2);
    #1;
    chk("wm_sel_hit", 32'(wm_sel), 1);
    xm_ir = itype(OP_SW, 0, 1);
    mw_ir = itype(OP_LW, 0, 2);
    #1;
    chk("wm_sel_r0", 32'(wm_sel), 0);
    xm_ir = '0;
    mw_ir = '0;
    dx_ir = itype(OP_LW, 4, 0);
    fd_ir = rtype(5'd0, 6, 4, 1);
    #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_bubble", 32'(bubble), 1);
    tick;
    dx_ir = '0;
    #1;
    chk("lu_release", 32'(stall), 0);
    chk("lu_cnt", lu_stall_cnt, 32'(PERF));
    dx_ir = itype(OP_LW, 4, 0);
    fd_ir = itype(OP_SW, 4, 1);
    #1;
    chk("lu_sw_data", 32'(stall), 0);
    fd_ir = itype(OP_SW, 1, 4);
    #1;
    chk("lu_sw_base", 32'(stall), 1);
    fd_ir = rtype(5'd0, 6, 4, 1);
    flush = 1'b1;
    #1;
    chk("lu_flush", 32'(stall), 0);
    flush = 1'b0;
    fd_ir = '0;
    dx_ir = rtype(ALU_MUL, 1, 2, 3);
    #1;
    chk("md_start0", 32'(md_start), 1);
    chk("md_stall0", 32'(stall), 1);
    chk("md_busy0", 32'(md_busy), 0);
    for (int c = 1; c < 4; c++) begin
      tick;
      chk($sformatf("md_busy_start%0d", c), 32'(md_start), 0);
      chk($sformatf("md_busy_stall%0d", c), 32'(stall), 1);
      chk($sformatf("md_busy_bubble%0d", c), 32'(bubble), 1);
      chk($sformatf("md_busy_flag%0d", c), 32'(md_busy), 1);
    end
    tick;
    chk("md_done_stall", 32'(stall), 0);
    chk("md_done_busy", 32'(md_busy), 1);
    chk("md_done_start", 32'(md_start), 0);
    chk("md_cnt", md_stall_cnt, 32'(4 * PERF));
    tick;
    chk("md_b2b_start", 32'(md_start), 1);
    chk("md_b2b_stall", 32'(stall), 1);
    tick;
    chk("md_b2b_busy", 32'(md_busy), 1);
    tick;
    flush = 1'b1;
    #1;
    chk("md_flush_stall", 32'(stall), 0);
    chk("md_flush_start", 32'(md_start), 0);
    tick;
    flush = 1'b0;
    dx_ir = '0;
    #1;
    chk("md_flush_busy", 32'(md_busy), 0);
    chk("md_flush_stall2", 32'(stall), 0);
    chk("md_cnt_flush", md_stall_cnt, 32'(6 * PERF));
    dx_ir = rtype(ALU_DIV, 1, 2, 3);
    flush = 1'b1;
    #1;
    chk("flush_idle_start", 32'(md_start), 0);
    flush = 1'b0;
    #1;
    chk("div_start", 32'(md_start), 1);
    tick;
    tick;
    dx_ir = '0;
    reset = 1'b1;
    #1;
    chk("rst_busy_stall", 32'(stall), 0);
    chk("rst_busy_flag", 32'(md_busy), 0);
    tick;
    reset = 1'b0;
    #1;
    chk("rst_rel_busy", 32'(md_busy), 0);
    chk("rst_rel_start", 32'(md_start), 0);
    chk("rst_rel_md_cnt", md_stall_cnt, 0);
    chk("rst_rel_lu_cnt", lu_stall_cnt, 0);
    tick;
    chk("idle_after_rst", 32'(md_busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
